// File: rtl/mem_access.sv
// mem_access: pipeline MEM stage. Issues loads and stores on a single-outstanding req/gnt/rvalid bus and registers MEM/WB.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into traps instead of bus requests.
`default_nettype none

module mem_access (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  logic [3:0]  mem_oper_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_waddr_i,
  input  logic        csr_we_i,
  input  logic        is_csr_i,
  input  logic        trap_i,
  input  logic        wb_use_mem_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rd_wdata_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [11:0] csr_waddr_o,
  output logic        csr_we_o,
  output logic        is_csr_o,
  output logic        trap_o
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic        w_is_load, w_is_store, w_unsigned, w_is_mem;
  logic [1:0]  w_size;
  logic        w_misalign, w_start_ok, w_complete, w_capture;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_result, w_load_sel;

  logic        r_hold, r_discard;
  logic [31:0] r_hold_data;
  logic [31:0] r_rd_wdata, r_csr_wdata;
  logic [11:0] r_csr_waddr;
  logic [4:0]  r_rd_addr;
  logic        r_write_rd, r_csr_we, r_is_csr, r_trap;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_unsigned = 1'b0;
    w_size     = SZ_WORD;
    case (mem_oper_i)
      MEM_LB:  begin w_is_load = 1'b1; w_size = SZ_BYTE; end
      MEM_LH:  begin w_is_load = 1'b1; w_size = SZ_HALF; end
      MEM_LW:  begin w_is_load = 1'b1; w_size = SZ_WORD; end
      MEM_LBU: begin w_is_load = 1'b1; w_size = SZ_BYTE; w_unsigned = 1'b1; end
      MEM_LHU: begin w_is_load = 1'b1; w_size = SZ_HALF; w_unsigned = 1'b1; end
      MEM_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE; end
      MEM_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF; end
      MEM_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD; end
      MEM_NOP: ;
      default: ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_is_mem &&
                      (((w_size == SZ_HALF) && alu_result_i[0]) ||
                       ((w_size == SZ_WORD) && (alu_result_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start_ok = w_is_mem && !trap_i && !w_misalign;

  // Lane steering: bus sees the aligned word, lanes selected by the low address bits.
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'h0;
    if (w_is_mem) begin
      case (w_size)
        SZ_BYTE: begin
          dmem_be_o    = 4'b0001 << alu_result_i[1:0];
          dmem_wdata_o = {4{alu_oper2_i[7:0]}};
        end
        SZ_HALF: begin
          dmem_be_o    = alu_result_i[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{alu_oper2_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = alu_oper2_i;
        end
      endcase
    end
  end

  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
  assign dmem_we_o   = w_is_store;

  assign w_byte = dmem_rdata_i[{alu_result_i[1:0], 3'b000} +: 8];
  assign w_half = alu_result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    case (w_size)
      SZ_BYTE: w_load_result = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_result = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_result = dmem_rdata_i;
    endcase
  end

  assign w_complete = (r_state == S_WAIT_RVALID) && dmem_rvalid_i;
  // A held response already completed the access, so IDLE must not re-issue it.
  assign w_capture  = ((r_state == S_IDLE) && (r_hold || !w_start_ok)) || w_complete;
  assign w_load_sel = r_hold ? r_hold_data : w_load_result;

  always_comb begin
    w_state_n  = r_state;
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok && !r_hold) begin
          dmem_req_o = 1'b1;
          stall_o    = 1'b1;
          w_state_n  = dmem_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) w_state_n = S_WAIT_RVALID;
      end
      S_WAIT_RVALID: begin
        if (dmem_rvalid_i) w_state_n = S_IDLE;
        else               stall_o   = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold      <= 1'b0;
      r_discard   <= 1'b0;
      r_hold_data <= 32'h0;
      r_rd_wdata  <= 32'h0;
      r_write_rd  <= 1'b0;
      r_rd_addr   <= 5'h0;
      r_csr_wdata <= 32'h0;
      r_csr_waddr <= 12'h0;
      r_csr_we    <= 1'b0;
      r_is_csr    <= 1'b0;
      r_trap      <= 1'b0;
    end else if (flush_i) begin
      r_write_rd <= 1'b0;
      r_csr_we   <= 1'b0;
      r_trap     <= 1'b0;
      r_hold     <= 1'b0;
      // An access still in flight finishes on the bus but its result is dropped.
      r_discard  <= (w_state_n != S_IDLE);
    end else if (stall_i) begin
      if (w_complete) begin
        r_hold      <= 1'b1;
        r_hold_data <= w_load_result;
      end
    end else if (w_capture) begin
      r_rd_wdata  <= wb_use_mem_i ? w_load_sel : alu_result_i;
      r_write_rd  <= write_rd_i && !w_misalign && !r_discard;
      r_rd_addr   <= rd_addr_i;
      r_csr_wdata <= csr_wdata_i;
      r_csr_waddr <= csr_waddr_i;
      r_csr_we    <= csr_we_i && !w_misalign && !r_discard;
      r_is_csr    <= is_csr_i;
      r_trap      <= (trap_i || w_misalign) && !r_discard;
      r_hold      <= 1'b0;
      r_discard   <= 1'b0;
    end
  end

  assign rd_wdata_o  = r_rd_wdata;
  assign write_rd_o  = r_write_rd;
  assign rd_addr_o   = r_rd_addr;
  assign csr_wdata_o = r_csr_wdata;
  assign csr_waddr_o = r_csr_waddr;
  assign csr_we_o    = r_csr_we;
  assign is_csr_o    = r_is_csr;
  assign trap_o      = r_trap;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: directed, table-driven bench for the mem_access MEM stage.
`default_nettype none

module tb_mem_access;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] alu_result_i, alu_oper2_i;
  logic [3:0]  mem_oper_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] csr_waddr_i;
  logic        csr_we_i, is_csr_i, trap_i, wb_use_mem_i, write_rd_i;
  logic [4:0]  rd_addr_i;
  logic        stall_i, flush_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        stall_o, write_rd_o, csr_we_o, is_csr_o, trap_o;
  logic [31:0] rd_wdata_o, csr_wdata_o;
  logic [4:0]  rd_addr_o;
  logic [11:0] csr_waddr_o;

  mem_access dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .alu_result_i(alu_result_i), .alu_oper2_i(alu_oper2_i), .mem_oper_i(mem_oper_i),
    .csr_wdata_i(csr_wdata_i), .csr_waddr_i(csr_waddr_i), .csr_we_i(csr_we_i),
    .is_csr_i(is_csr_i), .trap_i(trap_i), .wb_use_mem_i(wb_use_mem_i),
    .write_rd_i(write_rd_i), .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .rd_wdata_o(rd_wdata_o), .write_rd_o(write_rd_o), .rd_addr_o(rd_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_waddr_o(csr_waddr_o), .csr_we_o(csr_we_o),
    .is_csr_o(is_csr_o), .trap_o(trap_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        wbuse;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nreq, nstall, nwr;
    vecs[0] = '{MEM_LW,  32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{MEM_LB,  32'h103, 32'h0,        1'b1, 32'h80FF0000, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[2] = '{MEM_LBU, 32'h103, 32'h0,        1'b1, 32'h80FF0000, 4'b1000, 32'h0,        1'b0, 32'h00000080};
    vecs[3] = '{MEM_LH,  32'h102, 32'h0,        1'b1, 32'h80017FFF, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[4] = '{MEM_LHU, 32'h100, 32'h0,        1'b1, 32'h8001F00D, 4'b0011, 32'h0,        1'b0, 32'h0000F00D};
    vecs[5] = '{MEM_LB,  32'h101, 32'h0,        1'b1, 32'h00007F00, 4'b0010, 32'h0,        1'b0, 32'h0000007F};
    vecs[6] = '{MEM_LH,  32'h100, 32'h0,        1'b1, 32'h00008000, 4'b0011, 32'h0,        1'b0, 32'hFFFF8000};
    vecs[7] = '{MEM_SH,  32'h202, 32'h1234ABCD, 1'b0, 32'h11111111, 4'b1100, 32'hABCDABCD, 1'b1, 32'h00000202};
    vecs[8] = '{MEM_SB,  32'h301, 32'h000000A5, 1'b0, 32'h22222222, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h00000301};
    vecs[9] = '{MEM_SW,  32'h404, 32'hCAFEF00D, 1'b0, 32'h33333333, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h00000404};

    rstn_i = 1'b0;
    alu_result_i = 0; alu_oper2_i = 0; mem_oper_i = MEM_NOP;
    csr_wdata_i = 0; csr_waddr_i = 0; csr_we_i = 0; is_csr_i = 0; trap_i = 0;
    wb_use_mem_i = 0; write_rd_i = 0; rd_addr_i = 0; stall_i = 0; flush_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;

    smp();
    chk("rst_rd_wdata", rd_wdata_o, 32'h0);
    chk("rst_write_rd", {31'h0, write_rd_o}, 32'h0);
    chk("rst_trap", {31'h0, trap_o}, 32'h0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    step();
    rstn_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      mem_oper_i = vecs[i].op; alu_result_i = vecs[i].addr; alu_oper2_i = vecs[i].rs2;
      wb_use_mem_i = vecs[i].wbuse; write_rd_i = 1'b1; rd_addr_i = 5'(i); dmem_gnt_i = 1'b1;
      smp();
      chk($sformatf("v%0d_req", i), {31'h0, dmem_req_o}, 32'h1);
      chk($sformatf("v%0d_stall", i), {31'h0, stall_o}, 32'h1);
      chk($sformatf("v%0d_addr", i), dmem_addr_o, vecs[i].addr & 32'hFFFFFFFC);
      chk($sformatf("v%0d_be", i), {28'h0, dmem_be_o}, {28'h0, vecs[i].be});
      chk($sformatf("v%0d_we", i), {31'h0, dmem_we_o}, {31'h0, vecs[i].we});
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), dmem_wdata_o, vecs[i].wdata);
      step();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = vecs[i].rdata;
      smp();
      chk($sformatf("v%0d_stall_done", i), {31'h0, stall_o}, 32'h0);
      step();
      dmem_rvalid_i = 1'b0; dmem_rdata_i = 0; mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
      smp();
      chk($sformatf("v%0d_rd_wdata", i), rd_wdata_o, vecs[i].rd);
      chk($sformatf("v%0d_write_rd", i), {31'h0, write_rd_o}, 32'h1);
      chk($sformatf("v%0d_rd_addr", i), {27'h0, rd_addr_o}, 32'(i));
    end

    // Grant withheld three cycles, response two cycles after grant.
    nreq = 0; nstall = 0; nwr = 0;
    for (int t = 0; t < 9; t++) begin
      step();
      mem_oper_i = (t < 7) ? MEM_LW : MEM_NOP;
      alu_result_i = 32'h100; wb_use_mem_i = 1'b1; write_rd_i = (t < 7);
      dmem_gnt_i = (t == 3); dmem_rvalid_i = (t == 6);
      dmem_rdata_i = (t == 6) ? 32'hA5A50001 : 32'h0;
      smp();
      nreq += int'(dmem_req_o); nstall += int'(stall_o); nwr += int'(write_rd_o);
      if (t == 7) chk("slow_rd_wdata", rd_wdata_o, 32'hA5A50001);
    end
    chk("slow_req_cycles", 32'(nreq), 32'd4);
    chk("slow_stall_cycles", 32'(nstall), 32'd6);
    chk("slow_mwb_updates", 32'(nwr), 32'd1);

    // Flush while waiting for the response, then an ALU passthrough.
    step();
    mem_oper_i = MEM_LW; alu_result_i = 32'h100; wb_use_mem_i = 1'b1; write_rd_i = 1'b1; dmem_gnt_i = 1'b1;
    smp();
    chk("fl_req", {31'h0, dmem_req_o}, 32'h1);
    step();
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    smp();
    chk("fl_stall", {31'h0, stall_o}, 32'h1);
    step();
    flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h77;
    smp();
    chk("fl_stall_done", {31'h0, stall_o}, 32'h0);
    step();
    dmem_rvalid_i = 1'b0; mem_oper_i = MEM_NOP; alu_result_i = 32'd7; rd_addr_i = 5'd5;
    write_rd_i = 1'b1; wb_use_mem_i = 1'b0;
    smp();
    chk("fl_discard", {31'h0, write_rd_o}, 32'h0);
    chk("add_req", {31'h0, dmem_req_o}, 32'h0);
    chk("add_stall", {31'h0, stall_o}, 32'h0);
    step();
    write_rd_i = 1'b0;
    smp();
    chk("add_rd_wdata", rd_wdata_o, 32'd7);
    chk("add_rd_addr", {27'h0, rd_addr_o}, 32'd5);
    chk("add_write_rd", {31'h0, write_rd_o}, 32'h1);

    // Response arrives during stall_i: held until stall_i drops, no re-issue.
    step();
    mem_oper_i = MEM_LW; alu_result_i = 32'h10C; wb_use_mem_i = 1'b1; write_rd_i = 1'b1;
    rd_addr_i = 5'd9; dmem_gnt_i = 1'b1;
    smp();
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55AA55AA; stall_i = 1'b1;
    smp();
    chk("hold_stall_done", {31'h0, stall_o}, 32'h0);
    step();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'hFFFFFFFF;
    smp();
    chk("hold_noreq", {31'h0, dmem_req_o}, 32'h0);
    chk("hold_mwb", {31'h0, write_rd_o}, 32'h0);
    step();
    stall_i = 1'b0;
    smp();
    chk("hold_release_noreq", {31'h0, dmem_req_o}, 32'h0);
    step();
    mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    smp();
    chk("hold_rd_wdata", rd_wdata_o, 32'h55AA55AA);
    chk("hold_write_rd", {31'h0, write_rd_o}, 32'h1);
    chk("hold_rd_addr", {27'h0, rd_addr_o}, 32'd9);

    // Incoming trap suppresses the bus access; CSR fields pass through.
    step();
    mem_oper_i = MEM_LW; trap_i = 1'b1; alu_result_i = 32'h500; wb_use_mem_i = 1'b0; write_rd_i = 1'b1;
    csr_wdata_i = 32'h12345678; csr_waddr_i = 12'h341; csr_we_i = 1'b1; is_csr_i = 1'b1;
    smp();
    chk("trap_req", {31'h0, dmem_req_o}, 32'h0);
    chk("trap_stall", {31'h0, stall_o}, 32'h0);
    step();
    mem_oper_i = MEM_NOP; trap_i = 1'b0; write_rd_i = 1'b0; csr_we_i = 1'b0; is_csr_i = 1'b0;
    smp();
    chk("trap_o", {31'h0, trap_o}, 32'h1);
    chk("trap_csr_wdata", csr_wdata_o, 32'h12345678);
    chk("trap_csr_waddr", {20'h0, csr_waddr_o}, 32'h341);
    chk("trap_csr_we", {31'h0, csr_we_o}, 32'h1);
    chk("trap_is_csr", {31'h0, is_csr_o}, 32'h1);
    chk("trap_rd_wdata", rd_wdata_o, 32'h500);
    step();
    smp();
    chk("trap_clear", {31'h0, trap_o}, 32'h0);

    // Misaligned word load.
    step();
    mem_oper_i = MEM_LW; alu_result_i = 32'h101; wb_use_mem_i = 1'b1; write_rd_i = 1'b1; dmem_gnt_i = 1'b1;
    smp();
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", {31'h0, dmem_req_o}, 32'h0);
    chk("mis_stall", {31'h0, stall_o}, 32'h0);
    step();
    dmem_gnt_i = 1'b0; mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    smp();
    chk("mis_trap", {31'h0, trap_o}, 32'h1);
    chk("mis_write_rd", {31'h0, write_rd_o}, 32'h0);
`else
    chk("mis_req", {31'h0, dmem_req_o}, 32'h1);
    chk("mis_addr", dmem_addr_o, 32'h100);
    chk("mis_be", {28'h0, dmem_be_o}, 32'hF);
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
    smp();
    step();
    dmem_rvalid_i = 1'b0; mem_oper_i = MEM_NOP; write_rd_i = 1'b0;
    smp();
    chk("mis_rd_wdata", rd_wdata_o, 32'h0BADF00D);
    chk("mis_trap", {31'h0, trap_o}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage pipeline; consumes EX/MEM pipeline registers and produces MEM/WB pipeline registers.
- Runs loads/stores on a single-outstanding req/gnt/rvalid data bus, with byte-enable and store-data lane steering plus load extraction and extension.
- Holds the pipeline via stall_o until each bus transaction completes; non-memory instructions pass through in one cycle.

Parameters:
- none (XLEN fixed at 32; mem_oper_t from riscv_pkg: MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock, asynchronous, active-low
- alu_result_i  in  32  memory address, or rd value for non-memory ops
- alu_oper2_i  in  32  store data (rs2)
- mem_oper_i  in  mem_oper_t  memory operation
- csr_wdata_i / csr_waddr_i / csr_we_i / is_csr_i / trap_i  in  32/12/1/1/1  passed to MEM/WB
- wb_use_mem_i / write_rd_i  in  1/1; rd_addr_i  in  5
- stall_i  in  1  hold MEM/WB registers
- flush_i  in  1  bubble MEM/WB registers
- dmem_req_o  out  1; dmem_gnt_i  in  1
- dmem_addr_o  out  32; dmem_we_o  out  1; dmem_be_o  out  4; dmem_wdata_o  out  32
- dmem_rvalid_i  in  1; dmem_rdata_i  in  32
- stall_o  out  1  freeze IF..EX/MEM while access pending
- rd_wdata_o  out  32  value for WB; also used as the mem_wb forwarding data
- write_rd_o / rd_addr_o  out  1/5
- csr_wdata_o / csr_waddr_o / csr_we_o / is_csr_o / trap_o  out  32/12/1/1/1

Behaviour:
- Reset: state=IDLE. All MEM/WB outputs are 0. dmem_req_o=0 and stall_o=0 (both combinational, and 0 in IDLE with MEM_NOP).
- FSM states are IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE + mem op (not NOP, not trap_i): dmem_req_o=1 and stall_o=1 in the same cycle. gnt=1 -> WAIT_RVALID; gnt=0 -> WAIT_GNT.
  - WAIT_GNT: dmem_req_o=1 and stall_o=1; on gnt -> WAIT_RVALID.
  - WAIT_RVALID: dmem_req_o=0. On rvalid: stall_o=0, MEM/WB captures, next state IDLE. Otherwise stall_o=1.
- Address/data stability: bus outputs are combinational from EX/MEM inputs. Those inputs are frozen by stall_o, so they stay stable while req is high.
- dmem_addr_o = {alu_result_i[31:2], 2'b00}. dmem_we_o=1 for SB/SH/SW.
- Byte enables and store data:
  - Byte ops: be = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - Half ops: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - Word ops: be = 4'b1111, wdata = rs2.
- Loads: select the byte/half using addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Store response rdata is ignored.
- rd_wdata_o <= wb_use_mem_i ? load result : alu_result_i. Non-memory ops capture in one cycle with stall_o=0.
- Other MEM/WB fields register their inputs unchanged.
- Priority: rstn_i > flush_i > stall_i.
  - flush_i: MEM/WB write_rd_o, csr_we_o and trap_o are set to 0.
  - flush_i does not abort a granted transaction; the FSM still waits for rvalid and the result is discarded.
  - stall_i: MEM/WB held. A pending transaction continues, and rvalid data is held internally until stall_i drops.
- Back-to-back memory ops: the second request is issued in the cycle after the first rvalid at the earliest.
- Reset mid-transaction: the FSM returns to IDLE and any later rvalid is ignored; the bus is required to be reset together with the core.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is a half op with addr[0]=1, or a word op with addr[1:0]!=0.
  - A misaligned op issues no bus request; stall_o=0.
  - MEM/WB captures trap_o=1, write_rd_o=0, csr_we_o=0.
- Undefined: the offending low address bits are ignored. Half uses addr[1]; word uses the aligned word.

Test Plan:
- LW at 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> stall_o high 1 cycle; rd_wdata_o=0xDEADBEEF, write_rd_o=1.
- LB at 0x103, rdata 0x80FF_0000 -> rd_wdata_o=0xFFFFFF80; LBU at 0x103 -> 0x00000080.
- SH at 0x202 with rs2=0x1234ABCD -> dmem_be_o=4'b1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1, dmem_addr_o=0x200.
- gnt withheld 3 cycles, then rvalid after 2 more -> dmem_req_o high exactly 4 cycles, stall_o high 6 cycles, one MEM/WB update.
- flush_i asserted in WAIT_RVALID -> stall until rvalid, then write_rd_o=0; ADD passthrough rd=5 value 7 -> next cycle rd_wdata_o=7, no bus req.
- MISALIGN_TRAP_EN defined, LW at 0x101 -> dmem_req_o=0, trap_o=1, write_rd_o=0; undefined -> bus address 0x100.
